// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- definitions shared by the UART receiver and transmitter.
//   CLKS_PER_BIT_DEF : default bit time in clock cycles (9600 baud at 50 MHz)
//   FRAME_BITS       : start + 8 data + parity + stop
//   DATA_BITS        : payload width
//   uart_state_e     : receiver frame-decoder states
//   parity_bit()     : expected parity bit for a payload (1 for an even count
//                      of ones)
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int CLKS_PER_BIT_DEF = 5208;
   localparam int FRAME_BITS       = 11;
   localparam int DATA_BITS        = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } uart_state_e;

   function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if -- serial line plus received-byte status of the UART receiver.
//   RX         : serial line, idle high, asynchronous to the receiver clock
//   DATA       : last received byte
//   VALID      : one-cycle pulse when DATA is updated
//   PARITY_ERR : parity status of the last frame
//   FRAME_ERR  : stop-bit status of the last frame
//   BUSY       : receiver is inside a frame or a line break
// master = receiver side, slave = line driver / byte consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_if;
   import uart_pkg::*;

   logic                 RX;
   logic [DATA_BITS-1:0] DATA;
   logic                 VALID;
   logic                 PARITY_ERR;
   logic                 FRAME_ERR;
   logic                 BUSY;

   modport master (
      input  RX,
      output DATA, VALID, PARITY_ERR, FRAME_ERR, BUSY
   );

   modport slave (
      output RX,
      input  DATA, VALID, PARITY_ERR, FRAME_ERR, BUSY
   );

endinterface

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// rx_sync -- multi-flop synchronizer for an asynchronous, idle-high line.
//   CLOCK_50 : destination clock
//   RESET_N  : asynchronous active-low reset; all stages reset to 1 (idle)
//   d        : asynchronous input
//   q        : synchronized output, STAGES cycles behind d
// -----------------------------------------------------------------------------
module rx_sync #(
   parameter int STAGES = 2
) (
   input  logic CLOCK_50,
   input  logic RESET_N,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   // Resetting to 1 keeps the idle-high line from looking like a start bit
   // right after reset is released.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         ff <= '1;
      end else begin
         // NOTE: non-blocking assignments let every stage capture its
         // predecessor's old value, so the chain really is STAGES deep.
         ff[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            ff[i] <= ff[i-1];
         end
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8-bit UART receiver: start, 8 data bits LSB first, parity bit
// (even count of ones -> 1), stop.
//   CLOCK_50 : sole clock, rising edge
//   RESET_N  : asynchronous active-low reset
//   bus      : uart_rx_if.master (RX in; DATA, VALID, PARITY_ERR, FRAME_ERR,
//              BUSY out)
// Each bit is sampled once, at the middle of its bit time, measured from the
// synchronized falling edge of the start bit.
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int SYNC_STAGES  = 2
) (
   input  logic      CLOCK_50,
   input  logic      RESET_N,
   uart_rx_if.master bus
);

   localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]   CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam int                 IDX_W    = $clog2(DATA_BITS);
   localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic                 rx_s;
   uart_state_e          state_q,   state_d;
   logic [CNT_W-1:0]     cnt_q,     cnt_d;
   logic [IDX_W-1:0]     idx_q,     idx_d;
   logic [DATA_BITS-1:0] shift_q,   shift_d;
   logic                 par_bad_q, par_bad_d;  // parity verdict awaiting stop
   logic [DATA_BITS-1:0] data_q,    data_d;
   logic                 valid_q,   valid_d;
   logic                 perr_q,    perr_d;
   logic                 ferr_q,    ferr_d;

   rx_sync #(
      .STAGES  (SYNC_STAGES)
   ) u_sync (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .d        (bus.RX),
      .q        (rx_s)
   );

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         par_bad_q <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         par_bad_q <= par_bad_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before the case, so no path leaves
      // one unassigned and no latch is inferred.
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      idx_d     = idx_q;
      shift_d   = shift_q;
      par_bad_d = par_bad_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      perr_d    = perr_q;
      ferr_d    = ferr_q;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (!rx_s) state_d = ST_START;
         end
         ST_START: begin
            // Half a bit in: a line that is high again was only a glitch.
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               state_d = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s;
               if (idx_q == IDX_LAST) state_d = ST_PARITY;
               else                   idx_d   = idx_q + IDX_W'(1);
            end
         end
         ST_PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               par_bad_d = (rx_s != parity_bit(shift_q));
               state_d   = ST_STOP;
            end
         end
         ST_STOP: begin
            // The byte is delivered whatever the error flags say.
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               data_d  = shift_q;
               valid_d = 1'b1;
               perr_d  = par_bad_q;
               ferr_d  = ~rx_s;
               state_d = rx_s ? ST_IDLE : ST_BREAK;
            end
         end
         ST_BREAK: begin
            // Wait out a held-low line so it is not taken as a new start bit.
            cnt_d = '0;
            if (rx_s) state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.DATA       = data_q;
   assign bus.VALID      = valid_q;
   assign bus.PARITY_ERR = perr_q;
   assign bus.FRAME_ERR  = ferr_q;
   assign bus.BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx at 16 clocks per bit.
// Frames are driven bit by bit on RX; each driven frame pushes its expected
// byte, flags and VALID cycle onto a scoreboard that a negedge monitor pops
// whenever VALID is seen.
// -----------------------------------------------------------------------------
module tb_uart_rx;
   import uart_pkg::*;

   localparam int CPB       = 16;
   localparam int SYNC      = 2;
   localparam int FRAME_CYC = FRAME_BITS * CPB;
   // Edges from driving the start bit to VALID being visible: synchronizer,
   // one cycle to leave IDLE, half a bit to the start sample, then ten whole
   // bits to the stop sample; outputs load on that sample edge.
   localparam int VALID_LAT = SYNC + 1 + CPB / 2 + (FRAME_BITS - 1) * CPB;

   logic CLOCK_50 = 1'b0;
   logic RESET_N;
   int   cyc = 0;

   uart_rx_if bus ();

   uart_rx #(
      .CLKS_PER_BIT (CPB),
      .SYNC_STAGES  (SYNC)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .bus      (bus)
   );

   always #5 CLOCK_50 = ~CLOCK_50;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      int         at;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      int         hold;   // extra cycles RX stays low after a 0 stop bit
      logic       perr;
      logic       ferr;
   } frame_vec_t;

   exp_t       sb[$];
   int         valid_at[$];
   exp_t       mon_e;
   frame_vec_t vec[5];
   int         errors = 0;
   int         checks = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard consumer.
   always @(negedge CLOCK_50) begin
      if (bus.VALID === 1'b1) begin
         valid_at.push_back(cyc);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected VALID at cycle %0d: DATA=0x%0h, none expected",
                     cyc, bus.DATA);
         end else begin
            mon_e = sb.pop_front();
            check($sformatf("DATA of 0x%0h", mon_e.data), {24'b0, bus.DATA}, {24'b0, mon_e.data});
            check($sformatf("PARITY_ERR of 0x%0h", mon_e.data), {31'b0, bus.PARITY_ERR}, {31'b0, mon_e.perr});
            check($sformatf("FRAME_ERR of 0x%0h", mon_e.data), {31'b0, bus.FRAME_ERR}, {31'b0, mon_e.ferr});
            check($sformatf("VALID cycle of 0x%0h", mon_e.data), cyc, mon_e.at);
         end
      end
   end

   task automatic align();
      @(posedge CLOCK_50);
      #1;
   endtask

   // Hold RX at b for n clock edges; returns 1 ns after the last edge.
   task automatic drive_bit(input logic b, input int n);
      bus.RX = b;
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                             input logic perr, input logic ferr);
      exp_t e;
      e.data = d;
      e.perr = perr;
      e.ferr = ferr;
      e.at   = cyc + VALID_LAT;
      sb.push_back(e);
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
      drive_bit(par, CPB);
      drive_bit(stop, CPB);
   endtask

   // Wait, within a cycle budget, for the scoreboard to empty and BUSY to drop.
   task automatic wait_drain(input string name, input int budget);
      logic done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         if (sb.size() == 0 && bus.BUSY === 1'b0) done = 1'b1;
         else align();
      end
      check({name, " drained to IDLE"}, {31'b0, done}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int         base;
      logic [7:0] d;

      vec[0] = '{8'hA5, 1'b1, 1'b1, 0,  1'b0, 1'b0};  // clean frame
      vec[1] = '{8'h01, 1'b1, 1'b1, 0,  1'b1, 1'b0};  // wrong parity
      vec[2] = '{8'h3C, 1'b1, 1'b0, 40, 1'b0, 1'b1};  // stop 0, line break
      vec[3] = '{8'h55, 1'b1, 1'b1, 0,  1'b0, 1'b0};  // recovery after break
      vec[4] = '{8'hC3, 1'b0, 1'b0, 0,  1'b1, 1'b1};  // both errors, byte still out

      // Reset state.
      RESET_N = 1'b0;
      bus.RX  = 1'b1;
      repeat (3) @(posedge CLOCK_50);
      #1;
      check("reset DATA",       {24'b0, bus.DATA},       32'h00);
      check("reset VALID",      {31'b0, bus.VALID},      32'd0);
      check("reset PARITY_ERR", {31'b0, bus.PARITY_ERR}, 32'd0);
      check("reset FRAME_ERR",  {31'b0, bus.FRAME_ERR},  32'd0);
      check("reset BUSY",       {31'b0, bus.BUSY},       32'd0);
      RESET_N = 1'b1;
      drive_bit(1'b1, 5);

      // Table-driven frames.
      for (int i = 0; i < 5; i++) begin
         align();
         send_frame(vec[i].data, vec[i].par, vec[i].stop, vec[i].perr, vec[i].ferr);
         if (vec[i].hold > 0) begin
            drive_bit(1'b0, vec[i].hold);
            check($sformatf("BUSY held in break after 0x%0h", vec[i].data),
                  {31'b0, bus.BUSY}, 32'd1);
         end
         bus.RX = 1'b1;
         wait_drain($sformatf("frame 0x%0h", vec[i].data), 2 * CPB);
         drive_bit(1'b1, CPB);
      end

      // Back-to-back frames with no idle gap.
      align();
      base = valid_at.size();
      send_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
      send_frame(8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
      wait_drain("back-to-back", 2 * CPB);
      check("back-to-back VALID count", valid_at.size() - base, 32'd3);
      if (valid_at.size() >= base + 3) begin
         check("back-to-back spacing 1", valid_at[base+1] - valid_at[base],   FRAME_CYC);
         check("back-to-back spacing 2", valid_at[base+2] - valid_at[base+1], FRAME_CYC);
      end
      drive_bit(1'b1, CPB);

      // Five-cycle low glitch: BUSY rises, then falls with no VALID.
      base = valid_at.size();
      drive_bit(1'b0, 5);
      check("glitch BUSY raised", {31'b0, bus.BUSY}, 32'd1);
      bus.RX = 1'b1;
      wait_drain("glitch", 2 * CPB);
      check("glitch no VALID", valid_at.size() - base, 32'd0);
      drive_bit(1'b1, CPB);

      // Reset in the middle of bit 4 of 0x9F, then a fresh 0x42.
      align();
      base = valid_at.size();
      d    = 8'h9F;
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive_bit(d[i], CPB);
      drive_bit(d[4], CPB / 2);
      RESET_N = 1'b0;
      #2;
      check("mid-frame reset BUSY", {31'b0, bus.BUSY}, 32'd0);
      check("mid-frame reset DATA", {24'b0, bus.DATA}, 32'h00);
      bus.RX = 1'b1;
      repeat (4) @(posedge CLOCK_50);
      #1;
      RESET_N = 1'b1;
      drive_bit(1'b1, 2 * CPB);
      check("aborted 0x9F no VALID", valid_at.size() - base, 32'd0);
      check("idle after reset release", {31'b0, bus.BUSY}, 32'd0);
      align();
      send_frame(8'h42, 1'b1, 1'b1, 1'b0, 1'b0);
      wait_drain("frame 0x42", 2 * CPB);
      check("0x42 VALID count", valid_at.size() - base, 32'd1);

      drive_bit(1'b1, 4);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
